// File: rtl/f_fetch_unit_pkg.sv
// Shared constants for the fetch stage: reset/exception vectors, the legal
// instruction-memory window, CP0 exception codes and the NOP word.
package f_fetch_unit_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_TOP    = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // True when a fetch from pc must raise AdEL.
    function automatic logic fetch_addr_err(input logic [31:0] pc);
        logic err;
        err = (pc[1:0] != 2'b00);
`ifdef FETCH_RANGE_CHECK_EN
        if ((pc < IM_BASE) || (pc > IM_TOP)) begin
            err = 1'b1;
        end
`endif
        return err;
    endfunction

endpackage

// File: rtl/f_npc_sel.sv
// Next-PC priority mux for the fetch stage. Purely combinational.
// Priority: interrupt/exception > ERET > stall hold > branch/jump > PC+4.
module f_npc_sel
    import f_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        f_regen,
    input  logic        int_req,
    input  logic        d_eret,
    input  logic [31:0] epc,
    input  logic        d_jump,
    input  logic        d_cleardb,
    input  logic [31:0] d_npc,
    output logic [31:0] npc
);

    // Select the next PC; the interrupt redirect ignores the stall.
    always_comb begin
        npc = pc + 32'd4;
        if (int_req) begin
            npc = EXC_ENTRY;
        end else if (d_eret && f_regen) begin
            npc = epc;
        end else if (!f_regen) begin
            npc = pc;
        end else if (d_cleardb || d_jump) begin
            npc = d_npc;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection,
// AdEL detection and gating of the instruction handed to the D register.
// Optional macro FETCH_RANGE_CHECK_EN adds the IM_BASE..IM_TOP range check
// to AdEL; without it only misaligned fetch addresses raise AdEL.
//
// Flow control: F_REGen acts as the ready from the D register. When it is
// high the current F outputs are taken by D on the rising edge and the PC
// advances; when low the PC holds and F outputs stay stable. IntReq is the
// only redirect that is taken regardless of F_REGen.
module f_fetch_unit
    import f_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        F_REGen,
    input  logic        IntReq,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_jump,
    input  logic        D_isbj,
    input  logic        D_cleardb,
    input  logic [31:0] D_npc,
    input  logic [31:0] IM_rdata,
    output logic [31:0] IM_addr,
    output logic [31:0] F_PC,
    output logic [31:0] F_instr,
    output logic [4:0]  F_ExcCode,
    output logic        F_isdb
);

    logic [31:0] pc;
    logic [31:0] npc;

    f_npc_sel u_npc_sel (
        .pc        (pc),
        .f_regen   (F_REGen),
        .int_req   (IntReq),
        .d_eret    (D_eret),
        .epc       (EPC),
        .d_jump    (D_jump),
        .d_cleardb (D_cleardb),
        .d_npc     (D_npc),
        .npc       (npc)
    );

    // PC register; reset overrides any pending redirect or stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
        end else begin
            pc <= npc;
        end
    end

    // Present the fetch outputs; an AdEL or ERET wrong-path fetch is killed.
    always_comb begin
        F_PC      = pc;
        IM_addr   = pc;
        F_ExcCode = fetch_addr_err(pc) ? EXC_ADEL : EXC_NONE;
        F_instr   = ((F_ExcCode != EXC_NONE) || D_eret) ? NOP_WORD : IM_rdata;
        // D_cleardb deliberately leaves this set; D drops the annulled slot.
        F_isdb    = D_isbj && !D_eret;
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit. Each driven cycle pushes the expected
// {F_PC, F_instr, F_ExcCode, F_isdb} tuple; a monitor pops and compares it
// on the falling edge of the same cycle.
module tb_f_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_REGen;
    logic        IntReq;
    logic        D_eret;
    logic [31:0] EPC;
    logic        D_jump;
    logic        D_isbj;
    logic        D_cleardb;
    logic [31:0] D_npc;
    logic [31:0] IM_rdata;
    logic [31:0] IM_addr;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic [4:0]  F_ExcCode;
    logic        F_isdb;

    logic        im_force;
    logic [31:0] im_force_val;

    logic [69:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    f_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .F_REGen   (F_REGen),
        .IntReq    (IntReq),
        .D_eret    (D_eret),
        .EPC       (EPC),
        .D_jump    (D_jump),
        .D_isbj    (D_isbj),
        .D_cleardb (D_cleardb),
        .D_npc     (D_npc),
        .IM_rdata  (IM_rdata),
        .IM_addr   (IM_addr),
        .F_PC      (F_PC),
        .F_instr   (F_instr),
        .F_ExcCode (F_ExcCode),
        .F_isdb    (F_isdb)
    );

    // Instruction memory model: address-dependent nonzero word.
    function automatic logic [31:0] im_model(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always_comb begin
        IM_rdata = im_force ? im_force_val : im_model(IM_addr);
    end

    function automatic logic [4:0] exp_exc(input logic [31:0] pc);
        if (pc[1:0] != 2'b00) return 5'd4;
`ifdef FETCH_RANGE_CHECK_EN
        if ((pc < 32'h0000_3000) || (pc > 32'h0000_6FFC)) return 5'd4;
`endif
        return 5'd0;
    endfunction

    // ---------------- driver ----------------
    task automatic cyc(input logic rst, input logic regen, input logic intreq,
                       input logic eret, input logic jump, input logic isbj,
                       input logic cleardb, input logic [31:0] npc,
                       input logic [31:0] epc, input logic [31:0] pc_now,
                       input string nm);
        logic [4:0]  e_exc;
        logic [31:0] e_instr;
        logic        e_isdb;
        reset     = rst;
        F_REGen   = regen;
        IntReq    = intreq;
        D_eret    = eret;
        D_jump    = jump;
        D_isbj    = isbj;
        D_cleardb = cleardb;
        D_npc     = npc;
        EPC       = epc;
        e_exc     = exp_exc(pc_now);
        if ((e_exc != 5'd0) || eret) e_instr = 32'h0;
        else e_instr = im_force ? im_force_val : im_model(pc_now);
        e_isdb    = isbj & ~eret;
        exp_q.push_back({pc_now, e_instr, e_exc, e_isdb});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] pc_now, input string nm);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, pc_now, nm);
    endtask

    task automatic jmp(input logic [31:0] pc_now, input logic [31:0] tgt, input string nm);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, tgt, 32'h0, pc_now, nm);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [69:0] exp_v;
        logic [69:0] act_v;
        string       nm;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {F_PC, F_instr, F_ExcCode, F_isdb};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got pc=%h instr=%h exc=%0d isdb=%b, expected pc=%h instr=%h exc=%0d isdb=%b",
                         nm, act_v[69:38], act_v[37:6], act_v[5:1], act_v[0],
                         exp_v[69:38], exp_v[37:6], exp_v[5:1], exp_v[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; F_REGen = 1'b1; IntReq = 1'b0; D_eret = 1'b0; EPC = 32'h0;
        D_jump = 1'b0; D_isbj = 1'b0; D_cleardb = 1'b0; D_npc = 32'h0;
        im_force = 1'b0; im_force_val = 32'h0;
        @(posedge clk);
        #1;
        // Second reset cycle, with a pending jump that must be ignored.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5000, 32'h0, 32'h3000, "reset_hold");

        idle(32'h3000, "seq0");
        idle(32'h3004, "seq1");
        idle(32'h3008, "seq2");
        idle(32'h300C, "seq3");
        jmp(32'h3010, 32'h3100, "jump_dslot");
        idle(32'h3100, "jump_tgt");
        jmp(32'h3104, 32'h3020, "jump_3020");

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3200, 32'h0, 32'h3020, "stall");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3200, 32'h0, 32'h3020, "stall_rel");

        jmp(32'h3200, 32'h3102, "jump_mis");
        idle(32'h3102, "adel_adv");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h3106, "adel_int");
        idle(32'h4180, "exc_entry");
        jmp(32'h4184, 32'h6FFC, "jump_top");
        idle(32'h6FFC, "im_top");
        jmp(32'h7000, 32'h2FFC, "above_top");
        jmp(32'h2FFC, 32'h3300, "below_base");

        im_force = 1'b1; im_force_val = 32'h2408_0001;
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h3044, 32'h3300, "eret_kill");
        im_force = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3500, 32'h3044, "eret_stall");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3500, 32'h3044, "eret_retry");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3600, 32'h0, 32'h3500, "cleardb_jump");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3700, 32'h0, 32'h3600, "cleardb");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3500, 32'h3700, "int_eret_stall");
        jmp(32'h4180, 32'hFFFF_FFFC, "exc_entry2");
        idle(32'hFFFF_FFFC, "wrap_top");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3900, 32'h0, 32'h0000_0000, "reset_mid");
        idle(32'h3000, "after_reset");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- Fetch (F) stage of the 5-stage MIPS pipeline; upstream producer of the F→D pipeline register.
- Holds the PC and selects the next PC from sequential, branch/jump, ERET and exception/interrupt sources.
- Drives the instruction-memory address and presents F_PC, F_instr, F_ExcCode and F_isdb to the D register.
- Detects fetch address errors (AdEL) and flags delay-slot instructions for precise exceptions.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_TOP, 32'h0000_6FFC, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
F_REGen  in  1  1 = F may advance; 0 = stall, hold PC
IntReq  in  1  exception/interrupt accepted by CP0; redirect to EXC_ENTRY
D_eret  in  1  ERET is in D; redirect to EPC
EPC  in  32  return address from CP0
D_jump  in  1  D holds a taken branch/jump; next PC = D_npc
D_isbj  in  1  D holds any branch/jump, taken or not; F instr is its delay slot
D_cleardb  in  1  D holds a likely-branch whose delay slot is annulled
D_npc  in  32  branch/jump target computed in D
IM_rdata  in  32  instruction word at IM_addr (combinational IM)
IM_addr  out  32  instruction-memory address (= F_PC)
F_PC  out  32  current fetch PC
F_instr  out  32  fetched instruction, or 0 when killed
F_ExcCode  out  5  0 = none, 5'd4 = AdEL
F_isdb  out  1  F instruction is a delay slot

Behaviour:
- PC register, updated on posedge clk. Priority, highest first:
  - reset → PC_RESET
  - IntReq → EXC_ENTRY; ignores F_REGen
  - D_eret & F_REGen → EPC
  - !F_REGen → hold
  - D_cleardb → D_npc
  - D_jump → D_npc
  - otherwise → PC+4, wrapping modulo 2^32
- IM_addr = F_PC, combinational.
- F_ExcCode = 5'd4 when F_PC[1:0] != 0 or F_PC is outside [IM_BASE, IM_TOP]; otherwise 0.
- F_instr = 0 when F_ExcCode != 0 or D_eret = 1 (ERET has no delay slot; the wrong-path fetch is killed). Otherwise F_instr = IM_rdata.
- F_isdb = D_isbj & !D_eret, combinational.
  - D_cleardb does not clear F_isdb; the D register discards that instruction itself.
- Latency: a redirect asserted in cycle n is visible on F_PC in cycle n+1. No bubbles are inserted beyond those listed above.
- Reset values: F_PC = IM_addr = 32'h3000, F_ExcCode = 0, F_isdb = 0. F_instr follows IM_rdata.
- Reset mid-stall or mid-redirect: reset wins. No pending redirect survives reset.
- Simultaneous events:
  - IntReq + D_eret → EXC_ENTRY.
  - IntReq + !F_REGen → EXC_ENTRY.
  - D_eret + !F_REGen → hold; the ERET is retried next cycle.
  - D_cleardb + D_jump → D_npc.
- An AdEL PC still advances normally. The exception is taken only when IntReq returns from CP0.

Optional Feature:
- Macro FETCH_RANGE_CHECK_EN.
- Defined: AdEL is raised on misalignment or on an out-of-range PC, as above.
- Undefined: AdEL is raised only on F_PC[1:0] != 0. IM_BASE and IM_TOP are unused. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - constants PC_RESET, EXC_ENTRY, IM_BASE, IM_TOP
  - ExcCode constants EXC_NONE = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_RI = 5'd10, EXC_OV = 5'd12
  - the NOP word 32'h0
- One natural sub-module: f_npc_sel, the combinational priority mux producing the next PC. f_fetch_unit keeps the PC register, exception detection and output gating.

Test Plan:
- Reset held 2 cycles, then released with F_REGen = 1 and no redirects → F_PC = 3000, 3004, 3008 on successive cycles; F_ExcCode = 0; F_isdb = 0.
- At PC 3010: D_jump = 1, D_isbj = 1, D_npc = 3100 → this cycle F_isdb = 1 and F_instr = IM_rdata; next cycle F_PC = 3100.
- F_REGen = 0 for 3 cycles at PC 3020 while D_jump = 1 → F_PC stays 3020; then F_REGen = 1 → F_PC = D_npc.
- D_jump to D_npc = 3102 → F_PC = 3102, F_ExcCode = 4, F_instr = 0. Then IntReq = 1 → next F_PC = 4180. With the macro defined, D_npc = 7000 also gives F_ExcCode = 4.
- D_eret = 1, EPC = 3044, IM_rdata = 24080001 → this cycle F_instr = 0 and F_isdb = 0; next cycle F_PC = 3044.
- IntReq = 1 together with D_eret = 1 and F_REGen = 0 → next F_PC = 4180. Then reset = 1 at an arbitrary cycle → next F_PC = 3000.
